shift_pipe: RTL

Parametrised multi-stage shift register with a per-stage valid bit, shift enable, synchronous flush, a runtime-selectable tap output and an occupancy count. Generalises the single-bit clocked shift chain to WIDTH-bit data and DEPTH stages, so a datapath can delay a valid-qualified stream by a fixed or programmable number of enabled cycles. Used as a delay-matching element between pipeline stages.

---
 rtl/shift_pipe.sv | 87 ++++++++
 1 files changed

// File: rtl/shift_pipe.sv
// shift_pipe: WIDTH-bit, DEPTH-stage delay line with a valid bit per stage,
// shift enable, synchronous flush, a runtime tap and an occupancy count.
// Optional build macro SHIFT_PIPE_PAR_OUT_EN exposes every stage in parallel
// (stages_data_o / stages_valid_o).
module shift_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int TW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic [TW-1:0]    tap_sel_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             tap_valid_o,
  output logic [WIDTH-1:0] tap_data_o,
`ifdef SHIFT_PIPE_PAR_OUT_EN
  output logic [WIDTH*DEPTH-1:0] stages_data_o,
  output logic [DEPTH-1:0]       stages_valid_o,
`else
  // Parallel stage view not built in this configuration.
`endif
  output logic [CW-1:0]    count_o
);

  // Stage k lives at data_q[k]; stage DEPTH-1 is the output end.
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [CW-1:0]               count_q, count_d;

  // Next state: flush wins over shift, shift wins over hold.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    if (flush_i) begin
      data_d  = '0;
      valid_d = '0;
      count_d = '0;
    end else if (en_i) begin
      // Data moves even for invalid entries; the last stage falls off the end.
      data_d  = {data_q[DEPTH-2:0], in_data_i};
      valid_d = {valid_q[DEPTH-2:0], in_valid_i};
      // Track popcount(valid) incrementally: one in, possibly one out.
      count_d = count_q + CW'(in_valid_i) - CW'(valid_q[DEPTH-1]);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Tap mux: unregistered select, out-of-range indices read as empty.
  always_comb begin
    tap_valid_o = 1'b0;
    tap_data_o  = '0;
    if (32'(tap_sel_i) < DEPTH) begin
      tap_valid_o = valid_q[tap_sel_i];
      tap_data_o  = data_q[tap_sel_i];
    end
  end

  assign out_valid_o = valid_q[DEPTH-1];
  assign out_data_o  = data_q[DEPTH-1];
  assign count_o     = count_q;

`ifdef SHIFT_PIPE_PAR_OUT_EN
  // Packed layout puts stage k at bits [k*WIDTH +: WIDTH].
  assign stages_data_o  = data_q;
  assign stages_valid_o = valid_q;
`endif

endmodule
